// File: rtl/ysyx_22041412_clint.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp machine timer and msip software interrupt.
// Latency: a request accepted at edge T has its response valid from T+1. mtip_o lags the compare by one register.
// Backpressure: one request in flight. req_ready is low while a response waits for rsp_ready.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       request handshake; req_wen selects write (1) or read (0)
//   req_addr                  64-bit byte address. Only the three 8-byte-aligned registers decode.
//   req_wdata/req_wmask       write data and per-byte enables
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_err         read data (0 for writes and errors), decode error flag
//   mtip_o                    timer interrupt pending, level
//   msip_o                    software interrupt pending, level
module ysyx_22041412_clint #(
  parameter int unsigned TICK_DIV = 1,
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mtip_o,
  output logic        msip_o
);

  localparam logic [63:0] ADDR_MSIP     = BASE;
  localparam logic [63:0] ADDR_MTIMECMP = BASE + 64'h0000_0000_0000_4000;
  localparam logic [63:0] ADDR_MTIME    = BASE + 64'h0000_0000_0000_BFF8;
  // The prescaler counts 0..TICK_DIV-1. TICK_DIV=1 gives a tick on every cycle.
  localparam logic [15:0] TCNT_LAST     = 16'(TICK_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Handshake FSM and its registered outputs
  state_e      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [63:0] rsp_rdata_q;
  logic        rsp_err_q;

  // Timer and software-interrupt state
  logic [15:0] tcnt_q, tcnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic        mtip_q;

  // Request decode
  logic        accept;
  logic        aligned;
  logic        hit_msip, hit_mtimecmp, hit_mtime;
  logic        dec_err;
  logic        wr_msip, wr_mtimecmp, wr_mtime;
  logic [63:0] wmask64;
  logic [63:0] rd_data;
  logic        tick;

  always_comb begin
    accept       = (state_q == ST_IDLE) && req_valid;
    aligned      = (req_addr[2:0] == 3'b000);
    hit_msip     = aligned && (req_addr == ADDR_MSIP);
    hit_mtimecmp = aligned && (req_addr == ADDR_MTIMECMP);
    hit_mtime    = aligned && (req_addr == ADDR_MTIME);
    dec_err      = !(hit_msip || hit_mtimecmp || hit_mtime);

    // An erroring request never matches a register, so decode errors have no side effects.
    wr_msip      = accept && req_wen && hit_msip;
    wr_mtimecmp  = accept && req_wen && hit_mtimecmp;
    wr_mtime     = accept && req_wen && hit_mtime;
  end

  // Expand the byte enables into a bit mask.
  always_comb begin
    wmask64 = '0;
    for (int i = 0; i < 8; i++) begin
      wmask64[8*i +: 8] = {8{req_wmask[i]}};
    end
  end

  // Read data is sampled from the current register values, before any update at the accept edge.
  // Writes and decode errors return zero.
  always_comb begin
    rd_data = '0;
    if (!req_wen && !dec_err) begin
      if (hit_msip) begin
        rd_data = {63'b0, msip_q};
      end else if (hit_mtimecmp) begin
        rd_data = mtimecmp_q;
      end else begin
        rd_data = mtime_q;
      end
    end
  end

  // Prescaler and register next-state
  always_comb begin
    tick = (tcnt_q == TCNT_LAST);

    tcnt_d = tick ? 16'd0 : tcnt_q + 16'd1;

    // A software write to mtime overrides a tick on the same edge. The tick is lost and
    // the prescaler keeps its phase.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_mtime) begin
      mtime_d = (mtime_q & ~wmask64) | (req_wdata & wmask64);
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_mtimecmp) begin
      mtimecmp_d = (mtimecmp_q & ~wmask64) | (req_wdata & wmask64);
    end

    // Only bit 0 of msip is implemented. Upper bits are read as zero and writes to them are ignored.
    msip_d = msip_q;
    if (wr_msip) begin
      msip_d = (msip_q & ~wmask64[0]) | (req_wdata[0] & wmask64[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q     <= 16'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      tcnt_q     <= tcnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      // The compare uses this cycle's register values, so every change reaches mtip_o one edge later.
      // The level stays set until software moves mtimecmp above mtime or moves mtime below mtimecmp.
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  // Handshake FSM. The response is captured at the accept edge and held until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q     <= ST_RESP;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rd_data;
            rsp_err_q   <= dec_err;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mtip_o    = mtip_q;
  assign msip_o    = msip_q;

endmodule

// File: tb/tb_ysyx_22041412_clint.sv
// Directed testbench for ysyx_22041412_clint.
// u_clint uses TICK_DIV=1 and u_clint4 uses TICK_DIV=4. Both instances share the same request stream.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ysyx_22041412_clint;

  localparam logic [63:0] BASE  = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_ready;

  logic        req_ready, rsp_valid, rsp_err, mtip_o, msip_o;
  logic [63:0] rsp_rdata;
  logic        req_ready4, rsp_valid4, rsp_err4, mtip4, msip4;
  logic [63:0] rsp_rdata4;

  int checks;
  int errors;

  // Cycles since reset was released. This is the reference value of mtime when TICK_DIV=1.
  logic [63:0] cyc;

  // Values captured by do_req in its response cycle
  logic        r_vld;
  logic [63:0] r_dat;
  logic        r_err;
  logic [63:0] r_dat4;
  logic        r_mtip;

  ysyx_22041412_clint #(.TICK_DIV(1), .BASE(BASE)) u_clint (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mtip_o(mtip_o), .msip_o(msip_o)
  );

  ysyx_22041412_clint #(.TICK_DIV(4), .BASE(BASE)) u_clint4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready4), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4),
    .mtip_o(mtip4), .msip_o(msip4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 64'd0;
    else     cyc <= cyc + 64'd1;
  end

  // Call at 1 unit after an edge with the DUT idle and rsp_ready=1.
  // The request is accepted at the next edge and the response is captured one cycle later.
  // The task returns 1 unit after the edge that takes the DUT back to idle.
  task automatic do_req(input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_vld  = rsp_valid;
    r_dat  = rsp_rdata;
    r_err  = rsp_err;
    r_dat4 = rsp_rdata4;
    r_mtip = mtip_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    checks++; if (mtip_o !== 1'b0 || msip_o !== 1'b0) begin errors++; $display("FAIL reset_irq got mtip=%b msip=%b want 0 0", mtip_o, msip_o); end
    checks++;
    if (req_ready4 !== 1'b1 || rsp_valid4 !== 1'b0 || rsp_err4 !== 1'b0 || mtip4 !== 1'b0 || msip4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_div4 got rdy=%b vld=%b err=%b mtip=%b msip=%b want 1 0 0 0 0",
               req_ready4, rsp_valid4, rsp_err4, mtip4, msip4);
    end
    rst = 1'b0;
  endtask

  task automatic test_mtime_read;
    logic [63:0] exp;
    repeat (3) @(posedge clk);
    #1;
    exp = cyc;  // three cycles after release
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    checks++; if (r_vld !== 1'b1) begin errors++; $display("FAIL mtime_rsp_valid got %b want 1", r_vld); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL mtime_rsp_err got %b want 0", r_err); end
    checks++; if (r_dat !== exp || exp !== 64'd3) begin errors++; $display("FAIL mtime_read got %0d want %0d (3)", r_dat, exp); end
    // With TICK_DIV=4, four edges have not yet passed before the accept edge.
    checks++; if (r_dat4 !== 64'd0) begin errors++; $display("FAIL mtime_read_div4 got %0d want 0", r_dat4); end
  endtask

  task automatic test_timer;
    do_req(1'b1, A_CMP, 64'd20, 8'hFF);
    do_req(1'b1, A_TIME, 64'd0, 8'hFF);
    // mtime is 1 now. It reaches 20 after 19 more edges, and mtip must remain low throughout.
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      checks++; if (mtip_o !== 1'b0) begin errors++; $display("FAIL mtip_early step %0d got %b want 0", i, mtip_o); end
    end
    @(posedge clk); #1;
    checks++; if (mtip_o !== 1'b1) begin errors++; $display("FAIL mtip_rise got %b want 1", mtip_o); end
    do_req(1'b1, A_CMP, ONES, 8'hFF);
    checks++; if (r_mtip !== 1'b1) begin errors++; $display("FAIL mtip_hold_at_write got %b want 1", r_mtip); end
    checks++; if (mtip_o !== 1'b0) begin errors++; $display("FAIL mtip_clear got %b want 0", mtip_o); end
  endtask

  task automatic test_tick_div4;
    do_req(1'b1, A_TIME, 64'd0, 8'hFF);
    // Wait until 40 edges follow the write. Those edges contain exactly 10 ticks.
    repeat (39) @(posedge clk);
    #1;
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    checks++; if (r_dat4 !== 64'd10) begin errors++; $display("FAIL div4_40cyc got %0d want 10", r_dat4); end
    // Four edges later there must be exactly one more tick.
    repeat (2) @(posedge clk);
    #1;
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    checks++; if (r_dat4 !== 64'd11) begin errors++; $display("FAIL div4_step got %0d want 11", r_dat4); end
  endtask

  task automatic test_msip_and_mask;
    do_req(1'b1, A_MSIP, 64'hFFFF_FFFF, 8'h0F);
    checks++; if (r_err !== 1'b0 || r_dat !== 64'd0) begin errors++; $display("FAIL msip_write_rsp got err=%b data=%h want 0 0", r_err, r_dat); end
    checks++; if (msip_o !== 1'b1) begin errors++; $display("FAIL msip_set got %b want 1", msip_o); end
    do_req(1'b0, A_MSIP, 64'd0, 8'h00);
    checks++; if (r_dat !== 64'd1) begin errors++; $display("FAIL msip_readback got %h want 1", r_dat); end
    do_req(1'b1, A_MSIP, 64'd0, 8'hFF);
    checks++; if (msip_o !== 1'b0) begin errors++; $display("FAIL msip_clear got %b want 0", msip_o); end
    do_req(1'b1, A_MSIP, 64'd1, 8'h00);
    checks++; if (r_err !== 1'b0 || msip_o !== 1'b0) begin errors++; $display("FAIL wmask0_noop got err=%b msip=%b want 0 0", r_err, msip_o); end
    do_req(1'b0, A_MSIP, 64'd0, 8'h00);
    checks++; if (r_dat !== 64'd0) begin errors++; $display("FAIL msip_read_zero got %h want 0", r_dat); end
    do_req(1'b1, A_CMP, 64'h1122_3344_5566_7788, 8'h0F);
    do_req(1'b0, A_CMP, 64'd0, 8'h00);
    checks++; if (r_dat !== 64'hFFFF_FFFF_5566_7788) begin errors++; $display("FAIL partial_mask got %h want ffffffff55667788", r_dat); end
  endtask

  task automatic test_decode_err;
    do_req(1'b0, BASE + 64'h8, 64'd0, 8'h00);
    checks++; if (r_err !== 1'b1 || r_dat !== 64'd0) begin errors++; $display("FAIL err_read got err=%b data=%h want 1 0", r_err, r_dat); end
    do_req(1'b1, BASE + 64'h4004, 64'd0, 8'hFF);
    checks++; if (r_err !== 1'b1 || r_dat !== 64'd0) begin errors++; $display("FAIL err_write got err=%b data=%h want 1 0", r_err, r_dat); end
    do_req(1'b0, A_CMP, 64'd0, 8'h00);
    checks++; if (r_err !== 1'b0 || r_dat !== 64'hFFFF_FFFF_5566_7788) begin errors++; $display("FAIL err_no_change got err=%b data=%h want 0 ffffffff55667788", r_err, r_dat); end
  endtask

  task automatic test_stall;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_CMP; req_wdata = '0; req_wmask = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 64'hFFFF_FFFF_5566_7788) begin
        errors++;
        $display("FAIL stall cycle %0d got vld=%b rdy=%b data=%h want 1 0 ffffffff55667788", i, rsp_valid, req_ready, rsp_rdata);
      end
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stall_release got vld=%b rdy=%b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_wrap;
    do_req(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    @(posedge clk); #1;
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    checks++; if (r_dat !== 64'd0) begin errors++; $display("FAIL wrap got %h want 0", r_dat); end
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = A_CMP; req_wdata = 64'd5; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_resp got %b want 1", rsp_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_drop got vld=%b rdy=%b want 0 1", rsp_valid, req_ready); end
    rst = 1'b0;
    rsp_ready = 1'b1;
    do_req(1'b0, A_TIME, 64'd0, 8'h00);
    checks++; if (r_dat !== 64'd0) begin errors++; $display("FAIL rstmid_mtime got %h want 0", r_dat); end
    do_req(1'b0, A_CMP, 64'd0, 8'h00);
    checks++; if (r_dat !== ONES) begin errors++; $display("FAIL rstmid_mtimecmp got %h want ffffffffffffffff", r_dat); end
    checks++; if (mtip_o !== 1'b0 || msip_o !== 1'b0) begin errors++; $display("FAIL rstmid_irq got mtip=%b msip=%b want 0 0", mtip_o, msip_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mtime_read();
    test_timer();
    test_tick_div4();
    test_msip_and_mask();
    test_decode_err();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
